cpu_fpu_issue: RTL and testbench

- Requester-side sequencer for the FPU request/ready interface.
- Accepts one decoded floating-point operation from the execute stage and latches its operands.
- Holds the FPU request level-stable until the FPU answers, captures the result, and presents it to register-file writeback.
- Also enforces the mandatory request-low gap between operations and a watchdog timeout for a hung FPU sub-unit.

---
 rtl/cpu_fpu_issue_pkg.sv | 37 +++
 rtl/cpu_fpu_issue_if.sv | 39 +++
 rtl/cpu_fpu_issue_watchdog.sv | 54 +++++
 rtl/cpu_fpu_issue.sv | 121 ++++++++++++
 tb/tb_cpu_fpu_issue.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_fpu_issue_pkg.sv
// Shared definitions for the FPU issue sequencer: op codes, FSM state encoding and
// the integer-destination classifier used at accept time.
package cpu_fpu_issue_pkg;

   // FPU op codes
   localparam logic [4:0] FpuOpAdd       = 5'd0;
   localparam logic [4:0] FpuOpSub       = 5'd1;
   localparam logic [4:0] FpuOpMul       = 5'd2;
   localparam logic [4:0] FpuOpDiv       = 5'd3;
   localparam logic [4:0] FpuOpSqrt      = 5'd4;
   localparam logic [4:0] FpuOpMadd      = 5'd5;
   localparam logic [4:0] FpuOpMov       = 5'd6;
   localparam logic [4:0] FpuOpSgnj      = 5'd7;
   localparam logic [4:0] FpuOpSgnjn     = 5'd8;
   localparam logic [4:0] FpuOpSgnjx     = 5'd9;
   localparam logic [4:0] FpuOpMin       = 5'd10;
   localparam logic [4:0] FpuOpMax       = 5'd11;
   localparam logic [4:0] FpuOpF2I       = 5'd12;
   localparam logic [4:0] FpuOpI2F       = 5'd13;
   localparam logic [4:0] FpuOpCmpEqual  = 5'd14;
   localparam logic [4:0] FpuOpCmpLess   = 5'd15;
   localparam logic [4:0] FpuOpCmpLequal = 5'd16;

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StRequest   = 2'd1,
      StWriteback = 2'd2,
      StGap       = 2'd3
   } issue_state_e;

   // Ops whose result goes to the integer register file
   function automatic logic is_int_dest(input logic [4:0] op);
      return (op == FpuOpF2I) || (op == FpuOpCmpEqual) ||
             (op == FpuOpCmpLess) || (op == FpuOpCmpLequal);
   endfunction

endpackage

// File: rtl/cpu_fpu_issue_if.sv
// Execute-stage, FPU and writeback signals of the issue sequencer.
// slave: the sequencer itself; master: the surrounding pipeline / FPU.
interface cpu_fpu_issue_if #(
   parameter int unsigned CNT_W = 16
);
   logic             i_valid;
   logic             o_ready;
   logic [4:0]       i_op;
   logic [31:0]      i_op1;
   logic [31:0]      i_op2;
   logic [31:0]      i_op3;
   logic [4:0]       i_rd;
   logic             o_fpu_request;
   logic [4:0]       o_fpu_op;
   logic [31:0]      o_fpu_op1;
   logic [31:0]      o_fpu_op2;
   logic [31:0]      o_fpu_op3;
   logic             i_fpu_ready;
   logic [31:0]      i_fpu_result;
   logic             o_wb_valid;
   logic             i_wb_ready;
   logic [4:0]       o_wb_rd;
   logic             o_wb_int;
   logic [31:0]      o_wb_result;
   logic             o_fault;
   logic [CNT_W-1:0] o_last_latency;

   modport slave (
      input  i_valid, i_op, i_op1, i_op2, i_op3, i_rd, i_fpu_ready, i_fpu_result, i_wb_ready,
      output o_ready, o_fpu_request, o_fpu_op, o_fpu_op1, o_fpu_op2, o_fpu_op3,
             o_wb_valid, o_wb_rd, o_wb_int, o_wb_result, o_fault, o_last_latency
   );

   modport master (
      output i_valid, i_op, i_op1, i_op2, i_op3, i_rd, i_fpu_ready, i_fpu_result, i_wb_ready,
      input  o_ready, o_fpu_request, o_fpu_op, o_fpu_op1, o_fpu_op2, o_fpu_op3,
             o_wb_valid, o_wb_rd, o_wb_int, o_wb_result, o_fault, o_last_latency
   );
endinterface

// File: rtl/cpu_fpu_issue_watchdog.sv
// Request-cycle counter: saturating count, watchdog expiry and last-op latency capture.
module cpu_fpu_issue_watchdog #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_run,
   input  logic             i_done,
   output logic             o_expire,
   output logic [CNT_W-1:0] o_last_latency
);

   localparam logic [CNT_W:0] TimeoutVal = (CNT_W+1)'(TIMEOUT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W:0]   cnt_plus1;

   // Saturating increment doubles as the latency of an op completing this cycle
   assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   // Unsaturated compare so a wrapped counter can never alias the timeout
   assign cnt_plus1 = {1'b0, cnt_q} + (CNT_W+1)'(1);
   assign o_expire  = i_run && (TIMEOUT != 0) && (cnt_plus1 == TimeoutVal);
   assign o_last_latency = last_q;

   // Next counter and latency values
   always_comb begin
      cnt_d  = cnt_q;
      last_d = last_q;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_run) begin
         cnt_d = cnt_inc;
      end
      if (i_done) begin
         last_d = cnt_inc;
      end
   end

   // Counter and latency registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         cnt_q  <= '0;
         last_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/cpu_fpu_issue.sv
// FPU issue sequencer: accepts one op, holds the FPU request until ready or timeout,
// presents the result to writeback and enforces a one-cycle request-low gap.
module cpu_fpu_issue
   import cpu_fpu_issue_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input logic            i_clock,
   input logic            i_reset,
   cpu_fpu_issue_if.slave fpu_bus
);

   issue_state_e state_q, state_d;

   logic [4:0]       op_q;
   logic [31:0]      op1_q, op2_q, op3_q;
   logic [4:0]       rd_q;
   logic             int_q;
   logic [31:0]      result_q;
   logic             fault_q;
   logic             accept, done, expire, timeout;
   logic [CNT_W-1:0] last_latency;

   assign accept  = (state_q == StIdle) && fpu_bus.i_valid;
   assign done    = (state_q == StRequest) && fpu_bus.i_fpu_ready;
   // Ready in the expiry cycle takes priority over the fault
   assign timeout = expire && !fpu_bus.i_fpu_ready;

   cpu_fpu_issue_watchdog #(
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
   ) u_watchdog (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_clear       (accept),
      .i_run         (state_q == StRequest),
      .i_done        (done),
      .o_expire      (expire),
      .o_last_latency(last_latency)
   );

   // State register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:      if (fpu_bus.i_valid) state_d = StRequest;
         StRequest: begin
            if (fpu_bus.i_fpu_ready) begin
               state_d = StWriteback;
            end else if (expire) begin
               state_d = StGap;
            end
         end
         StWriteback: if (fpu_bus.i_wb_ready) state_d = StGap;
         StGap:       state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   // State-decoded handshake outputs
   always_comb begin
      fpu_bus.o_ready       = 1'b0;
      fpu_bus.o_fpu_request = 1'b0;
      fpu_bus.o_wb_valid    = 1'b0;
      unique case (state_q)
         StIdle:      fpu_bus.o_ready       = 1'b1;
         StRequest:   fpu_bus.o_fpu_request = 1'b1;
         StWriteback: fpu_bus.o_wb_valid    = 1'b1;
         StGap:       ;
         default:     ;
      endcase
   end

   // Operand latches on accept, result capture on FPU ready, registered fault pulse
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         op_q     <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         op3_q    <= '0;
         rd_q     <= '0;
         int_q    <= 1'b0;
         result_q <= '0;
         fault_q  <= 1'b0;
      end else begin
         if (accept) begin
            op_q  <= fpu_bus.i_op;
            op1_q <= fpu_bus.i_op1;
            op2_q <= fpu_bus.i_op2;
            op3_q <= fpu_bus.i_op3;
            rd_q  <= fpu_bus.i_rd;
            int_q <= is_int_dest(fpu_bus.i_op);
         end
         if (done) begin
            result_q <= fpu_bus.i_fpu_result;
         end
         fault_q <= timeout;
      end
   end

   assign fpu_bus.o_fpu_op       = op_q;
   assign fpu_bus.o_fpu_op1      = op1_q;
   assign fpu_bus.o_fpu_op2      = op2_q;
   assign fpu_bus.o_fpu_op3      = op3_q;
   assign fpu_bus.o_wb_rd        = rd_q;
   assign fpu_bus.o_wb_int       = int_q;
   assign fpu_bus.o_wb_result    = result_q;
   assign fpu_bus.o_fault        = fault_q;
   assign fpu_bus.o_last_latency = last_latency;

endmodule

// File: tb/tb_cpu_fpu_issue.sv
// Bench for cpu_fpu_issue: directed and random ops against a behavioural FPU and
// writeback sink; expected outcomes go into a scoreboard drained by a monitor.
module tb_cpu_fpu_issue;
   import cpu_fpu_issue_pkg::*;

   localparam int unsigned Timeout = 8;
   localparam int unsigned CntW    = 16;

   typedef struct {
      bit          fault;
      logic [4:0]  rd;
      bit          wb_int;
      logic [31:0] res;
      int          lat;
   } exp_t;

   logic i_clock = 1'b0;
   logic i_reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];
   exp_t mon_e;

   cpu_fpu_issue_if #(.CNT_W(CntW)) bus ();

   cpu_fpu_issue #(
      .TIMEOUT(Timeout),
      .CNT_W  (CntW)
   ) dut (
      .i_clock(i_clock),
      .i_reset(i_reset),
      .fpu_bus(bus)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Which ops write the integer register file
   function automatic bit tb_int_dest(input logic [4:0] op);
      case (op)
         FpuOpF2I, FpuOpCmpEqual, FpuOpCmpLess, FpuOpCmpLequal: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Monitor: compares every writeback / fault the DUT presents against the scoreboard
   always @(negedge i_clock) begin
      #2;
      if (bus.o_wb_valid || bus.o_fault) begin
         chk("event_expected", 128'(sb.size() != 0), 128'(1));
         if (sb.size() != 0) begin
            mon_e = sb[0];
            if (bus.o_fault) begin
               chk("fault_kind", 128'(mon_e.fault), 128'(1));
               chk("fault_no_wb", 128'(bus.o_wb_valid), 128'(0));
               void'(sb.pop_front());
            end else begin
               chk("wb_kind", 128'(mon_e.fault), 128'(0));
               chk("wb_rd", 128'(bus.o_wb_rd), 128'(mon_e.rd));
               chk("wb_int", 128'(bus.o_wb_int), 128'(mon_e.wb_int));
               chk("wb_result", 128'(bus.o_wb_result), 128'(mon_e.res));
               chk("last_latency", 128'(bus.o_last_latency), 128'(mon_e.lat));
               if (bus.i_wb_ready) void'(sb.pop_front());
            end
         end
      end
   end

   // Issue one op at the current negedge (DUT idle) and play FPU and writeback sink
   // until the DUT is ready again. lat > Timeout means the FPU never answers in time.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [4:0] rd, input int lat,
                         input logic [31:0] res, input int stall, input bit do_rst);
      exp_t e;
      int   edges, reqn, wbn, exp_edges;
      bit   back, rst_hit;
      edges = 0; reqn = 0; wbn = 0; back = 0; rst_hit = 0; exp_edges = 0;
      chk("ready_at_issue", 128'(bus.o_ready), 128'(1));
      bus.i_valid      = 1'b1;
      bus.i_op         = op;
      bus.i_op1        = a;
      bus.i_op2        = b;
      bus.i_op3        = c;
      bus.i_rd         = rd;
      bus.i_fpu_ready  = 1'($urandom);
      bus.i_fpu_result = $urandom;
      bus.i_wb_ready   = 1'($urandom);
      if (!do_rst) begin
         e.fault  = (lat > int'(Timeout));
         e.rd     = rd;
         e.wb_int = tb_int_dest(op);
         e.res    = res;
         e.lat    = lat;
         sb.push_back(e);
         exp_edges = e.fault ? int'(Timeout) + 2 : lat + stall + 3;
      end
      for (int k = 0; k < 300 && !back; k++) begin
         @(negedge i_clock);
         edges++;
         if (rst_hit) begin
            chk("rst_req_low", 128'(bus.o_fpu_request), 128'(0));
            chk("rst_no_wb", 128'(bus.o_wb_valid), 128'(0));
            chk("rst_ready", 128'(bus.o_ready), 128'(1));
            chk("rst_no_fault", 128'(bus.o_fault), 128'(0));
            i_reset = 1'b0;
            back    = 1'b1;
         end else if (bus.o_ready) begin
            back = 1'b1;
         end else begin
            // Junk on every input the DUT must ignore while busy
            bus.i_valid      = 1'($urandom);
            bus.i_op         = 5'($urandom);
            bus.i_op1        = $urandom;
            bus.i_op2        = $urandom;
            bus.i_op3        = $urandom;
            bus.i_rd         = 5'($urandom);
            bus.i_fpu_ready  = 1'($urandom);
            bus.i_fpu_result = $urandom;
            bus.i_wb_ready   = 1'($urandom);
            if (bus.o_fpu_request) begin
               reqn++;
               chk("operands_stable",
                   128'({bus.o_fpu_op, bus.o_fpu_op1, bus.o_fpu_op2, bus.o_fpu_op3}),
                   128'({op, a, b, c}));
               bus.i_fpu_ready = (reqn == lat);
               if (reqn == lat) bus.i_fpu_result = res;
               if (do_rst && reqn == 3) begin
                  i_reset         = 1'b1;
                  rst_hit         = 1'b1;
                  bus.i_fpu_ready = 1'b0;
               end
            end
            if (bus.o_wb_valid) begin
               bus.i_wb_ready = (wbn >= stall);
               wbn++;
            end
         end
      end
      bus.i_valid = 1'b0;
      chk("op_complete", 128'(back), 128'(1));
      if (!back) begin
         i_reset = 1'b1;
         @(negedge i_clock);
         @(negedge i_clock);
         i_reset = 1'b0;
         sb.delete();
      end else if (!do_rst) begin
         chk("cycles_to_ready", 128'(edges), 128'(exp_edges));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      bus.i_valid      = 1'b0;
      bus.i_op         = '0;
      bus.i_op1        = '0;
      bus.i_op2        = '0;
      bus.i_op3        = '0;
      bus.i_rd         = '0;
      bus.i_fpu_ready  = 1'b0;
      bus.i_fpu_result = '0;
      bus.i_wb_ready   = 1'b0;
      repeat (3) @(negedge i_clock);
      chk("reset_ready", 128'(bus.o_ready), 128'(1));
      chk("reset_request", 128'(bus.o_fpu_request), 128'(0));
      chk("reset_wb_valid", 128'(bus.o_wb_valid), 128'(0));
      chk("reset_fault", 128'(bus.o_fault), 128'(0));
      chk("reset_latency", 128'(bus.o_last_latency), 128'(0));
      chk("reset_wb_data", 128'({bus.o_wb_rd, bus.o_wb_int, bus.o_wb_result}), 128'(0));
      chk("reset_operands",
          128'({bus.o_fpu_op, bus.o_fpu_op1, bus.o_fpu_op2, bus.o_fpu_op3}), 128'(0));
      i_reset = 1'b0;
      @(negedge i_clock);

      run_op(FpuOpMov, 32'h1234_5678, 32'h0, 32'h0, 5'd1, 1, 32'h1234_5678, 0, 1'b0);
      run_op(FpuOpAdd, 32'h3F80_0000, 32'h4000_0000, 32'h0, 5'd2, 5, 32'h4040_0000, 0, 1'b0);
      run_op(FpuOpCmpLess, 32'h3F80_0000, 32'h4000_0000, 32'h0, 5'd3, 2, 32'h1, 0, 1'b0);
      run_op(FpuOpF2I, 32'h40A0_0000, 32'h0, 32'h0, 5'd4, 3, 32'h5, 0, 1'b0);
      run_op(FpuOpMul, 32'h4000_0000, 32'h4040_0000, 32'h0, 5'd5, 2, 32'h40C0_0000, 6, 1'b0);
      run_op(FpuOpDiv, 32'h3F80_0000, 32'h0, 32'h0, 5'd6, 1000, 32'h0, 0, 1'b0);
      run_op(FpuOpSqrt, 32'h4180_0000, 32'h0, 32'h0, 5'd7, 8, 32'h4080_0000, 1, 1'b0);
      run_op(FpuOpMadd, 32'h1, 32'h2, 32'h3, 5'd8, 20, 32'h0, 0, 1'b1);
      run_op(FpuOpSgnj, 32'hBF80_0000, 32'h3F80_0000, 32'h0, 5'd9, 1, 32'h3F80_0000, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_op(5'($urandom_range(0, 16)), $urandom, $urandom, $urandom, 5'($urandom),
                int'($urandom_range(1, 10)), $urandom, int'($urandom_range(0, 3)), 1'b0);
      end

      repeat (4) @(negedge i_clock);
      chk("scoreboard_drained", 128'(sb.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
